// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS systolic array: weight load, skewed compute, drain, done pulse.
// Optional busy/stall perf counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_seq_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             a_valid,
    output logic             a_ready,
    output logic             pe_w_en,
    output logic             pe_w_compute,
    output logic [ROWS-1:0]  feed_en,
    output logic [COLS-1:0]  out_valid,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
);
    localparam int BEAT_W = $clog2(ROWS + 1);
    localparam int DRN_W  = $clog2(ROWS + COLS);
    localparam int DLY_N  = ROWS + COLS - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [CNT_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_num_vec;
    logic [DRN_W-1:0]   r_drain;
    logic               r_busy;
    logic               r_done;
    logic               r_w_ready;
    logic               r_a_ready;
    logic               r_compute;
    logic [DLY_N-1:0]   r_dly;

    logic               w_w_fire;
    logic               w_a_fire;
    logic [DLY_N:0]     w_tap;

    assign w_w_fire = w_valid & r_w_ready;
    assign w_a_fire = a_valid & r_a_ready;
    // Tap k is a_fire delayed k cycles; a_fire is only ever high in COMPUTE.
    assign w_tap    = {r_dly, w_a_fire};

    assign busy         = r_busy;
    assign done         = r_done;
    assign w_ready      = r_w_ready;
    assign a_ready      = r_a_ready;
    assign pe_w_en      = w_w_fire;
    assign pe_w_compute = r_compute;
    assign feed_en      = w_tap[ROWS-1:0];
    assign out_valid    = w_tap[ROWS+COLS-1:ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else begin
            r_dly <= w_tap[DLY_N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_vec     <= '0;
            r_num_vec <= '0;
            r_drain   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w_ready <= 1'b0;
            r_a_ready <= 1'b0;
            r_compute <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD_W;
                        r_num_vec <= num_vec;
                        r_beat    <= '0;
                        r_vec     <= '0;
                        r_busy    <= 1'b1;
                        r_w_ready <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (w_w_fire) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == BEAT_W'(ROWS - 1)) begin
                            r_w_ready <= 1'b0;
                            if (r_num_vec != '0) begin
                                r_state   <= S_COMPUTE;
                                r_a_ready <= 1'b1;
                                r_compute <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_COMPUTE: begin
                    if (w_a_fire) begin
                        r_vec <= r_vec + CNT_W'(1);
                        if (r_vec == r_num_vec - CNT_W'(1)) begin
                            r_state   <= S_DRAIN;
                            r_a_ready <= 1'b0;
                            r_drain   <= DRN_W'(ROWS + COLS - 2);
                        end
                    end
                end
                S_DRAIN: begin
                    // Loaded with ROWS+COLS-2 so the state lasts ROWS+COLS-1 cycles.
                    if (r_drain == '0) begin
                        r_state   <= S_DONE;
                        r_compute <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DRN_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_w_ready <= 1'b0;
                    r_a_ready <= 1'b0;
                    r_compute <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_busy && r_perf_cycles != '1) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (r_state == S_COMPUTE && !a_valid && r_perf_stalls != '1) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for a ROWS x COLS systolic array of PE tiles. Runs one job per start: a weight-load phase (rows shifted in through `in_weight_above` under `pe_w_en`), then a compute phase (activation vectors streamed with per-row skew under `pe_w_compute`), then a drain phase until the last column result exits. Sits between the job/DMA front end (valid/ready streams) and the PE array, and provides the skew and result-valid strobes the array glue needs.

## Interface
- `ROWS`, 4, array rows; also the number of weight beats per job
- `COLS`, 4, array columns
- `CNT_W`, 16, width of the vector count
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request; sampled in IDLE only
- `num_vec`  in  CNT_W  activation vectors in this job; latched on accepted start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at job end
- `w_valid`  in  1  weight row beat available
- `w_ready`  out  1  controller accepts a weight beat
- `a_valid`  in  1  activation vector available
- `a_ready`  out  1  controller accepts an activation vector
- `pe_w_en`  out  1  broadcast weight-shift enable to the array
- `pe_w_compute`  out  1  broadcast compute enable to the array
- `feed_en`  out  ROWS  per-row activation injection strobe; the datapath injects 0 when a bit is low
- `out_valid`  out  COLS  per-column result-valid strobe at the array bottom
- `perf_cycles`  out  32  busy-cycle count (see Configuration)
- `perf_stalls`  out  32  COMPUTE cycles with `a_valid`=0 (see Configuration)

## Operation
- **States:** IDLE, LOAD_W, COMPUTE, DRAIN, DONE. Binary encoding; reset state is IDLE.
- **IDLE:**
  - On `start`=1, latch `num_vec`, clear the beat and vector counters, and go to LOAD_W.
  - `start` in any other state is ignored.
- **LOAD_W:**
  - `w_ready`=1.
  - w_fire = `w_valid` & `w_ready`; `pe_w_en` = w_fire (combinational).
  - Count fires. After the ROWS-th fire:
    - go to COMPUTE if the latched count is non-zero;
    - go to DONE if it is 0 (compute and drain are skipped).
  - `w_valid` gaps hold the state. There is no timeout.
- **COMPUTE:**
  - `a_ready`=1 and `pe_w_compute`=1.
  - a_fire = `a_valid` & `a_ready`.
  - Count fires. The fire that makes the count equal the latched `num_vec` moves the FSM to DRAIN.
- **DRAIN:**
  - `a_ready`=0 and `pe_w_compute`=1.
  - Stay exactly ROWS+COLS-1 cycles (down-counter), then go to DONE.
- **DONE:** one cycle with `done`=1 and `busy`=1, then IDLE. `pe_w_compute`=0.
- **Skew:**
  - `feed_en[0]` = a_fire (combinational).
  - `feed_en[r]` = a_fire delayed r cycles, r=1..ROWS-1, via a shift register.
- **Result valid:** `out_valid[c]` = a_fire delayed ROWS+c cycles, c=0..COLS-1, via a shift register of depth ROWS+COLS-1.
- **Shift-register clocking:** both delay lines shift every cycle in all states and shift in 0 outside COMPUTE, so bubbles propagate as zeros.
- **Counter widths:**
  - beat counter: clog2(ROWS+1) bits;
  - vector counter: CNT_W bits, no wrap (the maximum is 2^CNT_W-1);
  - drain counter: clog2(ROWS+COLS) bits.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; counters and delay lines 0. Assertion takes effect asynchronously and may occur in any state: the job is abandoned with no `done` pulse.
- **Load phase:** start accepted at edge E → LOAD_W from E; `w_ready` high in the cycle after E.
- **Back-to-back beats:** ROWS weight beats take ROWS cycles minimum.
- **Injection:** a vector fired in cycle t has `feed_en[r]` high in cycle t+r.
- **Result:** the same vector has `out_valid[c]` high in cycle t+ROWS+c.
- **Job end:** with the last vector fired in cycle t, `out_valid[COLS-1]` is high in cycle t+ROWS+COLS-1 and `done` is high in cycle t+ROWS+COLS.
- **Minimum job length:** for N vectors with no stalls, from the first LOAD_W cycle = ROWS + N + ROWS+COLS-1 + 1 cycles.
- **Next job:** `start` may be high during DONE but is ignored; the earliest accepted start is the first IDLE cycle after DONE.
- **Stalls:** `a_valid` stall cycles in COMPUTE add cycles 1:1 and insert zero bubbles; `pe_w_compute` stays high throughout.

## Configuration
- **`SYSTOLIC_CTRL_PERF_EN` defined:**
  - `perf_cycles` increments every cycle `busy`=1.
  - `perf_stalls` increments every COMPUTE cycle with `a_valid`=0.
  - Both counters clear on accepted start, hold after DONE, and saturate at 2^32-1.
  - Both reset to 0.
- **Not defined:** both ports are driven constant 0 and no counter logic is built. Control behaviour is identical in both builds.

## Test plan
- **Nominal job (ROWS=COLS=4):** start with `num_vec`=3, weights and activations always valid.
  - `pe_w_en` high 4 cycles.
  - `feed_en[3]` high for the vectors at t0+3..t0+5.
  - `out_valid[3]` last high at t_last+7.
  - `done` at t_last+8; `busy` falls the cycle after `done`.
- **Zero vectors:** `num_vec`=0 → 4 load beats, then `done` the next cycle; `pe_w_compute` never high.
- **Backpressure:**
  - `w_valid` toggles 1,0,1,0,… → exactly 4 `pe_w_en` pulses, LOAD_W lasts 7 cycles.
  - `a_valid` low for 2 cycles mid-COMPUTE with `num_vec`=5 → zero bubbles appear in `feed_en`/`out_valid`; with PERF_EN, `perf_stalls`=2.
- **Start while busy:** `start` held high for the whole job → exactly one `done`, then a second job starts from the first IDLE cycle after DONE.
- **Reset mid-COMPUTE:** `rst_n` low after 2 of 5 vectors → all outputs 0 immediately, no `done`; the next start runs a full clean job.
- **Perf counters:** PERF_EN build, `num_vec`=3 with no stalls → `perf_cycles`=4+3+7+1=15 and `perf_stalls`=0, both held after DONE.
